pc_sequencer: RTL and testbench

- Sequences the fetch PC register of the five-stage pipeline.
- Each cycle it decides whether the PC advances, by selecting next_pc and driving pc_en. It also drives the F/D and D/E pipeline-register enables and flushes.
- It owns the multi-cycle multiply/divide busy counter, so MD-dependent stalls are generated in one place.
- Sits between the D-stage decode/branch compare, the hazard unit, the coprocessor-0 exception logic, and the PC register.

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 55 +++++
 tb/tb_pc_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode/hazard/CP0 requests into the PC sequencer and its PC/pipeline-register controls.
interface pc_sequencer_if;
  logic [31:0] cur_pc;
  logic        hazard_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_req;
  logic [31:0] jmp_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        md_start;
  logic        md_is_div;
  logic        d_uses_md;
  logic [31:0] next_pc;
  logic        pc_en;
  logic        fd_en;
  logic        fd_clr;
  logic        de_clr;
  logic        stall;
  logic        md_busy;
  modport master (
    output cur_pc, hazard_stall, br_taken, br_target, jmp_req, jmp_target,
           exc_req, eret_req, epc, md_start, md_is_div, d_uses_md,
    input  next_pc, pc_en, fd_en, fd_clr, de_clr, stall, md_busy
  );
  modport slave (
    input  cur_pc, hazard_stall, br_taken, br_target, jmp_req, jmp_target,
           exc_req, eret_req, epc, md_start, md_is_div, d_uses_md,
    output next_pc, pc_en, fd_en, fd_clr, de_clr, stall, md_busy
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC selection, F/D and D/E enables/flushes, and the multiply/divide busy counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
  parameter int          MULT_CYCLES = 5,
  parameter int          DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] md_state, md_state_nx;
  logic [3:0] md_cnt, md_cnt_nx, md_load;
  logic       busy, stl, redirect;
  assign md_load = 4'((bus.md_is_div ? DIV_CYCLES : MULT_CYCLES) - 1);
  always_comb begin
    md_state_nx = md_state;
    md_cnt_nx   = md_cnt;
    if (bus.md_start) begin
      md_state_nx = BUSY;
      md_cnt_nx   = md_load;
    end else if (md_state == BUSY) begin
      md_state_nx = md_cnt == 4'd0 ? IDLE : BUSY;
      md_cnt_nx   = md_cnt == 4'd0 ? 4'd0 : md_cnt - 4'd1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_state <= IDLE;
      md_cnt   <= 4'd0;
    end else begin
      md_state <= md_state_nx;
      md_cnt   <= md_cnt_nx;
    end
  end
  // exception and eret redirect the PC even through a stall
  assign busy     = ~reset & (md_state == BUSY);
  assign stl      = ~reset & (bus.hazard_stall | (bus.d_uses_md & (busy | bus.md_start)));
  assign redirect = bus.exc_req | bus.eret_req;
  assign bus.md_busy = busy;
  assign bus.stall   = stl;
  assign bus.next_pc = reset        ? RESET_PC :
                       bus.exc_req  ? EXC_VECTOR :
                       bus.eret_req ? bus.epc :
                       stl          ? bus.cur_pc :
                       bus.br_taken ? bus.br_target :
                       bus.jmp_req  ? bus.jmp_target :
                                      bus.cur_pc + 32'd4;
  assign bus.pc_en  = reset | ~stl | redirect;
  assign bus.fd_en  = bus.pc_en;
  assign bus.fd_clr = reset | redirect;
  assign bus.de_clr = reset | bus.exc_req | (stl & ~bus.eret_req);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of PC selection, pipeline controls and MD busy timing.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  pc_sequencer_if bus();
  pc_sequencer dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cur_pc = 32'h0; bus.hazard_stall = 0; bus.br_taken = 0; bus.br_target = 32'h0;
    bus.jmp_req = 0; bus.jmp_target = 32'h0; bus.exc_req = 0; bus.eret_req = 0;
    bus.epc = 32'h0; bus.md_start = 0; bus.md_is_div = 0; bus.d_uses_md = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    #1;
    total++;
    if ({bus.next_pc, bus.pc_en, bus.fd_clr, bus.de_clr, bus.md_busy, bus.stall} !== {32'h3000, 5'b11100}) begin
      bad++;
      $display("FAIL reset_outputs: got pc=%h en=%b fdclr=%b declr=%b busy=%b stall=%b want 3000 1 1 1 0 0",
               bus.next_pc, bus.pc_en, bus.fd_clr, bus.de_clr, bus.md_busy, bus.stall);
    end
    tick();
    bus.cur_pc = 32'h3000;
    reset = 0;
    #1;
    total++;
    if ({bus.next_pc, bus.pc_en, bus.de_clr, bus.fd_clr} !== {32'h3004, 3'b100}) begin
      bad++;
      $display("FAIL seq_3004: got pc=%h en=%b declr=%b fdclr=%b want 3004 1 0 0", bus.next_pc, bus.pc_en, bus.de_clr, bus.fd_clr);
    end
    tick();
    bus.cur_pc = 32'h3004;
    #1;
    total++;
    if ({bus.next_pc, bus.pc_en, bus.de_clr} !== {32'h3008, 2'b10}) begin
      bad++;
      $display("FAIL seq_3008: got pc=%h en=%b declr=%b want 3008 1 0", bus.next_pc, bus.pc_en, bus.de_clr);
    end
  endtask

  task automatic test_branch();
    tick();
    clear_inputs();
    bus.cur_pc = 32'h3010; bus.br_taken = 1; bus.br_target = 32'h3040;
    bus.jmp_req = 1; bus.jmp_target = 32'h5550;
    #1;
    total++;
    if ({bus.next_pc, bus.fd_clr, bus.pc_en, bus.de_clr} !== {32'h3040, 3'b010}) begin
      bad++;
      $display("FAIL branch: got pc=%h fdclr=%b en=%b declr=%b want 3040 0 1 0", bus.next_pc, bus.fd_clr, bus.pc_en, bus.de_clr);
    end
    bus.br_taken = 0;
    #1;
    total++;
    if (bus.next_pc !== 32'h5550) begin
      bad++;
      $display("FAIL jump: got %h want 5550", bus.next_pc);
    end
    bus.br_taken = 1; bus.jmp_req = 0; bus.hazard_stall = 1;
    #1;
    total++;
    if ({bus.pc_en, bus.fd_en, bus.de_clr, bus.stall, bus.fd_clr} !== 5'b00110) begin
      bad++;
      $display("FAIL branch_stall: got en=%b fden=%b declr=%b stall=%b fdclr=%b want 0 0 1 1 0",
               bus.pc_en, bus.fd_en, bus.de_clr, bus.stall, bus.fd_clr);
    end
  endtask

  task automatic test_md(input bit div, input int n);
    tick();
    clear_inputs();
    bus.cur_pc = 32'h3100;
    bus.md_start = 1; bus.md_is_div = div; bus.d_uses_md = 1;
    #1;
    total++;
    if ({bus.stall, bus.pc_en, bus.md_busy} !== 3'b100) begin
      bad++;
      $display("FAIL md_start_cycle div=%0d: got stall=%b en=%b busy=%b want 1 0 0", div, bus.stall, bus.pc_en, bus.md_busy);
    end
    tick();
    bus.md_start = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      total++;
      if ({bus.md_busy, bus.stall, bus.pc_en} !== 3'b110) begin
        bad++;
        $display("FAIL md_busy div=%0d cyc=%0d: got busy=%b stall=%b en=%b want 1 1 0", div, i, bus.md_busy, bus.stall, bus.pc_en);
      end
      tick();
    end
    #1;
    total++;
    if ({bus.md_busy, bus.stall, bus.pc_en, bus.next_pc} !== {3'b001, 32'h3104}) begin
      bad++;
      $display("FAIL md_done div=%0d: got busy=%b stall=%b en=%b pc=%h want 0 0 1 3104", div, bus.md_busy, bus.stall, bus.pc_en, bus.next_pc);
    end
  endtask

  task automatic test_exc_keeps_md();
    tick();
    clear_inputs();
    bus.md_start = 1;
    tick();
    bus.md_start = 0; bus.exc_req = 1;
    tick();
    bus.exc_req = 0;
    #1;
    total++;
    if (bus.md_busy !== 1'b1) begin
      bad++;
      $display("FAIL exc_md_abort: got busy=%b want 1", bus.md_busy);
    end
    for (int i = 0; i < 3; i++) tick();
    #1;
    total++;
    if (bus.md_busy !== 1'b1) begin
      bad++;
      $display("FAIL exc_md_last: got busy=%b want 1", bus.md_busy);
    end
    tick();
    #1;
    total++;
    if (bus.md_busy !== 1'b0) begin
      bad++;
      $display("FAIL exc_md_end: got busy=%b want 0", bus.md_busy);
    end
  endtask

  task automatic test_exception();
    tick();
    clear_inputs();
    bus.cur_pc = 32'h3200; bus.hazard_stall = 1; bus.eret_req = 1; bus.exc_req = 1; bus.epc = 32'h3abc;
    #1;
    total++;
    if ({bus.next_pc, bus.pc_en, bus.fd_clr, bus.de_clr} !== {32'h4180, 3'b111}) begin
      bad++;
      $display("FAIL exception: got pc=%h en=%b fdclr=%b declr=%b want 4180 1 1 1", bus.next_pc, bus.pc_en, bus.fd_clr, bus.de_clr);
    end
    bus.exc_req = 0; bus.hazard_stall = 0;
    #1;
    total++;
    if ({bus.next_pc, bus.fd_clr, bus.de_clr, bus.pc_en} !== {32'h3abc, 3'b101}) begin
      bad++;
      $display("FAIL eret: got pc=%h fdclr=%b declr=%b en=%b want 3abc 1 0 1", bus.next_pc, bus.fd_clr, bus.de_clr, bus.pc_en);
    end
    bus.hazard_stall = 1;
    #1;
    total++;
    if ({bus.next_pc, bus.pc_en, bus.de_clr} !== {32'h3abc, 2'b10}) begin
      bad++;
      $display("FAIL eret_stall: got pc=%h en=%b declr=%b want 3abc 1 0", bus.next_pc, bus.pc_en, bus.de_clr);
    end
  endtask

  task automatic test_async_reset();
    tick();
    clear_inputs();
    bus.cur_pc = 32'h5000;
    bus.md_start = 1; bus.md_is_div = 1;
    tick();
    bus.md_start = 0;
    tick();
    tick();
    #1;
    total++;
    if (bus.md_busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_busy: got %b want 1", bus.md_busy);
    end
    reset = 1;
    #1;
    total++;
    if ({bus.md_busy, bus.next_pc} !== {1'b0, 32'h3000}) begin
      bad++;
      $display("FAIL async_reset: got busy=%b pc=%h want 0 3000", bus.md_busy, bus.next_pc);
    end
    #1;
    reset = 0;
    #1;
    total++;
    if ({bus.md_busy, bus.next_pc} !== {1'b0, 32'h5004}) begin
      bad++;
      $display("FAIL post_reset: got busy=%b pc=%h want 0 5004", bus.md_busy, bus.next_pc);
    end
    tick();
    total++;
    if (bus.md_busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got busy=%b want 0", bus.md_busy);
    end
  endtask

  task automatic test_wrap();
    tick();
    clear_inputs();
    bus.cur_pc = 32'hFFFF_FFFC;
    #1;
    total++;
    if (bus.next_pc !== 32'h0) begin
      bad++;
      $display("FAIL wrap: got %h want 00000000", bus.next_pc);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_md(1'b1, 10);
    test_md(1'b0, 5);
    test_exc_keeps_md();
    test_exception();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
